// File: rtl/alu_exec_if.sv
// Handshake bundle between decode, the execute ALU and its consumer.
// Overflow wire exists only when ALU_OVF_EN is defined.
interface alu_exec_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef ALU_OVF_EN
    logic             overflow;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, overflow
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, overflow
    );
`else
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
`endif
endinterface

// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with a main + skid output buffer.
// Optional signed-overflow flag is built when ALU_OVF_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    alu_exec_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_res_q, main_res_d;
    logic             main_zero_q, main_zero_d;
    logic [WIDTH-1:0] skid_res_q, skid_res_d;
    logic             skid_zero_q, skid_zero_d;
    logic [WIDTH-1:0] alu_res;
    logic             alu_zero;
    logic             accept;

    always_comb begin
        alu_res = '0;
        case (bus.op)
            3'b000:  alu_res = bus.a + bus.b;
            3'b001:  alu_res = bus.a - bus.b;
            3'b010:  alu_res = bus.a & bus.b;
            3'b011:  alu_res = bus.a | bus.b;
            3'b100:  alu_res = bus.a ^ bus.b;
            3'b101:  alu_res = ~(bus.a | bus.b);
            3'b110:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
        endcase
    end

    assign alu_zero = (alu_res == '0);
    // in_ready depends only on the registered state, never on out_ready.
    assign accept   = bus.in_valid && (state_q != ST_TWO);

`ifdef ALU_OVF_EN
    logic main_ovf_q, main_ovf_d;
    logic skid_ovf_q, skid_ovf_d;
    logic alu_ovf;

    always_comb begin
        alu_ovf = 1'b0;
        if (bus.op == 3'b000)
            alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
        else if (bus.op == 3'b001)
            alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
    end
`endif

    always_comb begin
        state_d     = state_q;
        main_res_d  = main_res_q;
        main_zero_d = main_zero_q;
        skid_res_d  = skid_res_q;
        skid_zero_d = skid_zero_q;
`ifdef ALU_OVF_EN
        main_ovf_d  = main_ovf_q;
        skid_ovf_d  = skid_ovf_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d     = ST_ONE;
                    main_res_d  = alu_res;
                    main_zero_d = alu_zero;
`ifdef ALU_OVF_EN
                    main_ovf_d  = alu_ovf;
`endif
                end
            end
            ST_ONE: begin
                if (accept && bus.out_ready) begin
                    main_res_d  = alu_res;
                    main_zero_d = alu_zero;
`ifdef ALU_OVF_EN
                    main_ovf_d  = alu_ovf;
`endif
                end else if (accept) begin
                    state_d     = ST_TWO;
                    skid_res_d  = alu_res;
                    skid_zero_d = alu_zero;
`ifdef ALU_OVF_EN
                    skid_ovf_d  = alu_ovf;
`endif
                end else if (bus.out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (bus.out_ready) begin
                    state_d     = ST_ONE;
                    main_res_d  = skid_res_q;
                    main_zero_d = skid_zero_q;
`ifdef ALU_OVF_EN
                    main_ovf_d  = skid_ovf_q;
`endif
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_res_q  <= '0;
            main_zero_q <= 1'b0;
            skid_res_q  <= '0;
            skid_zero_q <= 1'b0;
`ifdef ALU_OVF_EN
            main_ovf_q  <= 1'b0;
            skid_ovf_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            main_res_q  <= main_res_d;
            main_zero_q <= main_zero_d;
            skid_res_q  <= skid_res_d;
            skid_zero_q <= skid_zero_d;
`ifdef ALU_OVF_EN
            main_ovf_q  <= main_ovf_d;
            skid_ovf_q  <= skid_ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q != ST_TWO);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.result    = main_res_q;
    assign bus.zero      = main_zero_q;
`ifdef ALU_OVF_EN
    assign bus.overflow  = main_ovf_q;
`endif
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed test-plan cases plus
// randomized traffic scored against a queue-based arithmetic model.
module tb_alu_exec_unit;
    localparam int W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   bp_mode;
    int   pops;
    exp_t exp_q[$];

    alu_exec_if #(.WIDTH(W)) bus_if();

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference computed with wide signed/unsigned integer arithmetic.
    function automatic exp_t ref_alu(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint ux, uy, sx, sy, full, modv, smax, smin;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        modv = longint'(1) << W;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -(longint'(1) << (W - 1));
        full = 0;
        e.ovf = 1'b0;
        case (o)
            3'd0: begin full = sx + sy; e.res = W'((ux + uy) % modv); e.ovf = (full > smax) || (full < smin); end
            3'd1: begin full = sx - sy; e.res = W'((ux - uy + modv) % modv); e.ovf = (full > smax) || (full < smin); end
            3'd2: e.res = x & y;
            3'd3: e.res = x | y;
            3'd4: e.res = x ^ y;
            3'd5: e.res = ~(x | y);
            3'd6: e.res = (sx < sy) ? W'(1) : W'(0);
            default: e.res = (ux < uy) ? W'(1) : W'(0);
        endcase
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Downstream ready generator: 0 = stall, 1 = always ready, 2 = random.
    initial begin
        bus_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (bp_mode)
                0:       bus_if.out_ready = 1'b0;
                1:       bus_if.out_ready = 1'b1;
                default: bus_if.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: observes both handshakes mid-cycle, when everything is settled.
    initial begin
        logic         prev_stall;
        logic [W-1:0] prev_res;
        exp_t         e;
        prev_stall = 1'b0;
        prev_res   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                check("in_ready_occ", 32'(bus_if.in_ready), 32'(exp_q.size() < 2));
                check("out_valid_occ", 32'(bus_if.out_valid), 32'(exp_q.size() != 0));
                if (prev_stall)
                    check("stable_result", 32'(bus_if.result), 32'(prev_res));
                if (bus_if.out_valid && bus_if.out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    pops++;
                    check("result", 32'(bus_if.result), 32'(e.res));
                    check("zero", 32'(bus_if.zero), 32'(e.zero));
`ifdef ALU_OVF_EN
                    check("overflow", 32'(bus_if.overflow), 32'(e.ovf));
`endif
                end
                if (bus_if.in_valid && bus_if.in_ready)
                    exp_q.push_back(ref_alu(bus_if.op, bus_if.a, bus_if.b));
                prev_stall = bus_if.out_valid && !bus_if.out_ready;
                prev_res   = bus_if.result;
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int waits);
        logic done;
        bus_if.in_valid = 1'b1;
        bus_if.op = o;
        bus_if.a  = x;
        bus_if.b  = y;
        waits = 0;
        done  = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (bus_if.in_ready) done = 1'b1;
            else begin
                waits++;
                if (waits > 50) begin
                    check("send_timeout", 32'(waits), 32'd0);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.op = 3'($urandom);
        bus_if.a  = W'($urandom);
        bus_if.b  = W'($urandom);
    endtask

    task automatic set_bp(input int m);
        bp_mode = m;
        @(posedge clk);
        #3;
    endtask

    task automatic drain();
        int n;
        n = 0;
        set_bp(1);
        while (bus_if.out_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", 32'(bus_if.out_valid), 32'd0);
    endtask

    // Send one op into an empty unit with a ready consumer and check the exact value.
    task automatic send_expect(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W-1:0] r, input logic z);
        int w;
        send(o, x, y, w);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus_if.out_valid), 32'd1);
        check({tag, "_res"}, 32'(bus_if.result), 32'(r));
        check({tag, "_zero"}, 32'(bus_if.zero), 32'(z));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, stalls, pops0;
        tests = 0;
        fails = 0;
        pops  = 0;
        bp_mode = 1;
        rst = 1'b1;
        bus_if.in_valid = 1'b0;
        bus_if.op = '0;
        bus_if.a  = '0;
        bus_if.b  = '0;
        #2;
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst_result", 32'(bus_if.result), 32'd0);
        check("rst_zero", 32'(bus_if.zero), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        set_bp(1);

        // Asynchronous reset while a result is held.
        set_bp(0);
        send(3'd0, 16'd3, 16'd4, w);
        @(negedge clk);
        check("pre_rst_valid", 32'(bus_if.out_valid), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(bus_if.out_valid), 32'd0);
        check("async_rst_ready", 32'(bus_if.in_ready), 32'd1);
        check("async_rst_result", 32'(bus_if.result), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_bp(1);

        // Directed arithmetic cases.
        send_expect("add_ovf", 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0);
`ifdef ALU_OVF_EN
        check("add_ovf_flag", 32'(bus_if.overflow), 32'd1);
`endif
        send_expect("sub_eq", 3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1);
        send_expect("slt", 3'd6, 16'hFFFF, 16'h0001, 16'h0001, 1'b0);
        send_expect("sltu", 3'd7, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        drain();

        // Backpressure: two accepted, third held until release.
        set_bp(0);
        send(3'd0, 16'h0001, 16'h0001, w);
        send(3'd2, 16'h00F0, 16'h0FF0, w);
        check("bp_second_wait", 32'(w), 32'd0);
        bus_if.in_valid = 1'b1;
        bus_if.op = 3'd3;
        bus_if.a  = 16'h000F;
        bus_if.b  = 16'h0F00;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus_if.in_ready), 32'd0);
            check("bp_hold", 32'(bus_if.result), 32'h0002);
        end
        @(posedge clk);
        #1;
        pops0 = pops;
        set_bp(1);
        send(3'd3, 16'h000F, 16'h0F00, w);
        @(negedge clk);
        @(negedge clk);
        check("bp_release_pops", 32'(pops - pops0), 32'd3);
        drain();

        // Streaming: eight XORs at full rate.
        stalls = 0;
        pops0 = pops;
        for (int i = 0; i < 8; i++) begin
            send(3'd4, W'($urandom), W'($urandom), w);
            stalls += w;
        end
        check("stream_stalls", 32'(stalls), 32'd0);
        @(negedge clk);
        check("stream_pops", 32'(pops - pops0), 32'd8);
        drain();

        // Reset while both entries are full.
        set_bp(0);
        send(3'd0, 16'h1111, 16'h2222, w);
        send(3'd1, 16'h9999, 16'h1111, w);
        @(negedge clk);
        check("two_in_ready", 32'(bus_if.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("two_rst_valid", 32'(bus_if.out_valid), 32'd0);
        check("two_rst_result", 32'(bus_if.result), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_bp(1);
        send_expect("post_rst", 3'd4, 16'h1234, 16'h00FF, 16'h12CB, 1'b0);
        drain();

        // Randomized traffic with random downstream stalls.
        set_bp(2);
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(3'($urandom), W'($urandom), W'($urandom), w);
        end
        drain();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
